// File: rtl/rv_mem_port.sv
// rv_mem_port: byte-addressed data memory with valid/ready request/response handshake
module rv_mem_port #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 4096,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int NB = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH_BYTES];
  logic [AW-1:0] addr_q, s_addr;
  logic [1:0] size_q, s_size, cnt;
  logic uns_q, wr_q, err_q, s_uns, rd_zero, sgn, err, accept;
  logic [DATA_W-1:0] rdata_q, raw, msk, ld;
  logic [3:0] nb;
  logic [ADDR_W:0] end_addr;
  assign req_ready  = state == IDLE && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = state == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign nb       = 4'd1 << req_size;
  assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(nb);
  assign err = (|(req_addr[2:0] & 3'(nb - 4'd1))) || end_addr > (ADDR_W+1)'(DEPTH_BYTES)
               || (req_size == 2'd3 && DATA_W == 32);
  // With READ_LAT=1 the array is read on the accept edge, so take the live request fields
  assign s_addr  = state == IDLE ? req_addr[AW-1:0] : addr_q;
  assign s_size  = state == IDLE ? req_size : size_q;
  assign s_uns   = state == IDLE ? req_unsigned : uns_q;
  assign rd_zero = state == IDLE ? (err || req_write) : (err_q || wr_q);
  always_comb begin
    raw = '0;
    for (int i = 0; i < NB; i++) raw[8*i +: 8] = mem[s_addr + AW'(i)];
  end
  assign msk = s_size == 2'd0 ? DATA_W'(8'hFF) : s_size == 2'd1 ? DATA_W'(16'hFFFF) :
               s_size == 2'd2 ? DATA_W'(32'hFFFF_FFFF) : '1;
  assign sgn = !s_uns && (s_size == 2'd0 ? raw[7] : s_size == 2'd1 ? raw[15] :
               s_size == 2'd2 ? raw[31] : raw[DATA_W-1]);
  assign ld  = (raw & msk) | (sgn ? ~msk : '0);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = (err || READ_LAT == 1) ? RESP : WAIT;
    else if (state == WAIT && cnt == 2'd0) state_n = RESP;
    else if (state == RESP && resp_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr[AW-1:0];
        size_q <= req_size;
        uns_q  <= req_unsigned;
        wr_q   <= req_write;
        err_q  <= err;
        cnt    <= 2'(READ_LAT - 2);
      end else if (state == WAIT) cnt <= cnt - 2'd1;
      if (state_n == RESP && state != RESP) rdata_q <= rd_zero ? '0 : ld;
      else if (state == RESP && resp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept && !err && req_write)
      for (int i = 0; i < NB; i++)
        if (4'(i) < nb) mem[req_addr[AW-1:0] + AW'(i)] <= req_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_rv_mem_port.sv
// tb_rv_mem_port: scoreboard bench for a 32-bit/READ_LAT=1 and a 64-bit/READ_LAT=3 build
module tb_rv_mem_port;
  logic clk = 1'b0, rst = 1'b1;
  logic v32 = 1'b0, v64 = 1'b0, rrdy = 1'b0, wr = 1'b0, uns = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0] size = '0;
  logic [63:0] wdata = '0;
  logic rdy32, rdy64, rv32, rv64, err32, err64;
  logic [31:0] rd32;
  logic [63:0] rd64;
  int checks = 0, failures = 0;
  typedef struct { logic [63:0] rd; logic err; int lat; } exp_t;
  exp_t q[$];
  logic [7:0] mm [int];

  always #5 clk = ~clk;

  rv_mem_port #(.DATA_W(32), .READ_LAT(1)) u32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32), .req_write(wr),
    .req_addr(addr), .req_size(size), .req_unsigned(uns), .req_wdata(wdata[31:0]),
    .resp_valid(rv32), .resp_ready(rrdy), .resp_rdata(rd32), .resp_err(err32));
  rv_mem_port #(.DATA_W(64), .READ_LAT(3)) u64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64), .req_write(wr),
    .req_addr(addr), .req_size(size), .req_unsigned(uns), .req_wdata(wdata),
    .resp_valid(rv64), .resp_ready(rrdy), .resp_rdata(rd64), .resp_err(err64));

  function automatic logic f_rv(input bit s);  return s ? rv64 : rv32;   endfunction
  function automatic logic f_rdy(input bit s); return s ? rdy64 : rdy32; endfunction
  function automatic logic f_err(input bit s); return s ? err64 : err32; endfunction
  function automatic logic [63:0] f_rd(input bit s); return s ? rd64 : {32'b0, rd32}; endfunction

  task automatic xact(input bit s, input bit w, input logic [31:0] a, input logic [1:0] sz,
                      input bit u, input logic [63:0] wd, input logic [63:0] erd,
                      input bit eerr, input int elat, input int hold, input string name);
    exp_t e;
    int n;
    q.push_back('{rd: erd, err: eerr, lat: elat});
    wr = w; addr = a; size = sz; uns = u; wdata = wd;
    if (s) v64 = 1'b1; else v32 = 1'b1;
    checks++;
    if (f_rdy(s) !== 1'b1) begin
      failures++; $display("FAIL %s ready_idle got=%b want=1", name, f_rdy(s));
    end
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    n = 1;
    while (f_rv(s) !== 1'b1 && n < 12) begin
      checks++;
      if (f_rdy(s) !== 1'b0) begin
        failures++; $display("FAIL %s ready_wait got=%b want=0", name, f_rdy(s));
      end
      @(posedge clk); #1;
      n++;
    end
    e = q.pop_front();
    checks++;
    if (n != e.lat) begin
      failures++; $display("FAIL %s latency got=%0d want=%0d", name, n, e.lat);
    end
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (f_rv(s) !== 1'b1 || f_rdy(s) !== 1'b0 || f_err(s) !== e.err || f_rd(s) !== e.rd) begin
        failures++;
        $display("FAIL %s resp[%0d] got v=%b rdy=%b err=%b rd=%h want v=1 rdy=0 err=%b rd=%h",
                 name, i, f_rv(s), f_rdy(s), f_err(s), f_rd(s), e.err, e.rd);
      end
      if (i < hold) begin @(posedge clk); #1; end
    end
    rrdy = 1'b1;
    @(posedge clk); #1;
    rrdy = 1'b0;
    checks++;
    if (f_rv(s) !== 1'b0 || f_rdy(s) !== 1'b1 || f_rd(s) !== 64'd0 || f_err(s) !== 1'b0) begin
      failures++;
      $display("FAIL %s retire got v=%b rdy=%b rd=%h err=%b want v=0 rdy=1 rd=0 err=0",
               name, f_rv(s), f_rdy(s), f_rd(s), f_err(s));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy32, rv32, err32, rd32, rdy64, rv64, err64, rd64} !== '0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b%b v=%b%b err=%b%b rd=%h/%h want all 0",
               rdy32, rdy64, rv32, rv64, err32, err64, rd32, rd64);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rdy32, rdy64, rv32, rv64} !== 4'b1100) begin
      failures++;
      $display("FAIL post_reset got rdy=%b%b v=%b%b want rdy=11 v=00", rdy32, rdy64, rv32, rv64);
    end
  endtask

  task automatic test_store_load();
    xact(0, 1, 32'h10, 2, 0, 64'hDEADBEEF, 64'h0, 0, 1, 0, "st_w_10");
    xact(0, 0, 32'h10, 2, 0, 64'h0, 64'hDEADBEEF, 0, 1, 0, "ld_w_10");
  endtask

  task automatic test_extend();
    xact(0, 0, 32'h13, 0, 0, 64'h0, 64'hFFFFFFDE, 0, 1, 0, "ld_b_s");
    xact(0, 0, 32'h13, 0, 1, 64'h0, 64'h000000DE, 0, 1, 0, "ld_b_u");
    xact(0, 0, 32'h10, 1, 0, 64'h0, 64'hFFFFBEEF, 0, 1, 0, "ld_h_s");
    xact(0, 0, 32'h12, 1, 1, 64'h0, 64'h0000DEAD, 0, 1, 0, "ld_h_u");
    xact(0, 0, 32'h11, 0, 1, 64'h0, 64'h000000BE, 0, 1, 0, "ld_b_11");
  endtask

  task automatic test_errors();
    xact(0, 0, 32'h12, 2, 0, 64'h0, 64'h0, 1, 1, 0, "mis_w");
    xact(0, 1, 32'hFFC, 2, 0, 64'h11223344, 64'h0, 0, 1, 0, "st_top");
    xact(0, 1, 32'hFFF, 1, 0, 64'hAAAA, 64'h0, 1, 1, 0, "st_h_fff");
    xact(0, 0, 32'hFFC, 2, 0, 64'h0, 64'h11223344, 0, 1, 0, "ld_top");
    xact(0, 0, 32'h1000, 0, 0, 64'h0, 64'h0, 1, 1, 0, "oob_b");
    xact(0, 0, 32'h8000_0010, 2, 0, 64'h0, 64'h0, 1, 1, 0, "hi_addr");
    xact(0, 1, 32'hFFFF_FFFC, 2, 0, 64'h5, 64'h0, 1, 1, 0, "wrap_sum");
    xact(0, 0, 32'h10, 2, 0, 64'h0, 64'hDEADBEEF, 0, 1, 0, "no_alias");
  endtask

  task automatic test_latency();
    xact(1, 1, 32'h20, 2, 0, 64'h12345678, 64'h0, 0, 3, 5, "lat_st");
    xact(1, 0, 32'h20, 2, 0, 64'h0, 64'h12345678, 0, 3, 5, "lat_ld");
    xact(1, 0, 32'h22, 2, 0, 64'h0, 64'h0, 1, 1, 3, "lat_err");
  endtask

  task automatic test_double();
    xact(1, 1, 32'h8, 3, 0, 64'h0123456789ABCDEF, 64'h0, 0, 3, 0, "st_d");
    xact(1, 0, 32'h8, 3, 0, 64'h0, 64'h0123456789ABCDEF, 0, 3, 0, "ld_d");
    xact(1, 0, 32'hC, 2, 0, 64'h0, 64'h0000000001234567, 0, 3, 0, "ld_w_hi");
    xact(1, 0, 32'h8, 2, 0, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, 3, 0, "ld_w_sx");
    xact(1, 0, 32'h4, 3, 0, 64'h0, 64'h0, 1, 1, 0, "mis_d");
    xact(0, 0, 32'h8, 3, 0, 64'h0, 64'h0, 1, 1, 0, "d_on_32");
  endtask

  task automatic test_reset_mid();
    xact(1, 1, 32'h40, 2, 0, 64'hCAFEF00D, 64'h0, 0, 3, 0, "st_40");
    for (int k = 0; k < 2; k++) begin
      wr = (k == 1); addr = k == 1 ? 32'h48 : 32'h40; size = 2; uns = 0; wdata = 64'h5555AAAA;
      v64 = 1'b1;
      @(posedge clk); #1;
      v64 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rv64 !== 1'b0 || rdy64 !== 1'b0) begin
        failures++; $display("FAIL rst_mid%0d in_reset got v=%b rdy=%b want 0 0", k, rv64, rdy64);
      end
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        checks++;
        if (rv64 !== 1'b0 || rdy64 !== 1'b1) begin
          failures++; $display("FAIL rst_mid%0d after[%0d] got v=%b rdy=%b want 0 1", k, c, rv64, rdy64);
        end
      end
    end
    xact(1, 0, 32'h40, 2, 1, 64'h0, 64'h00000000CAFEF00D, 0, 3, 0, "ld_40_u");
    xact(1, 0, 32'h40, 2, 0, 64'h0, 64'hFFFFFFFFCAFEF00D, 0, 3, 0, "ld_40_s");
    xact(1, 0, 32'h48, 2, 0, 64'h0, 64'h000000005555AAAA, 0, 3, 0, "ld_48_kept");
  endtask

  task automatic test_back_to_back();
    logic [63:0] v, wd, erd;
    logic [31:0] a;
    logic [1:0] sz;
    bit w, u;
    int nbt;
    for (int k = 0; k < 16; k++) begin
      wd = {32'b0, $urandom()};
      a = 32'h100 + 32'(4 * k);
      for (int b = 0; b < 4; b++) mm[int'(a) + b] = wd[8*b +: 8];
      xact(0, 1, a, 2, 0, wd, 64'h0, 0, 1, 0, "fill");
    end
    for (int k = 0; k < 24; k++) begin
      sz = 2'($urandom_range(0, 2));
      nbt = 1 << sz;
      a = (32'h100 + 32'($urandom_range(0, 63))) & ~32'(nbt - 1);
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      wd = {$urandom(), $urandom()};
      erd = '0;
      if (w) for (int b = 0; b < nbt; b++) mm[int'(a) + b] = wd[8*b +: 8];
      else begin
        v = '0;
        for (int b = 0; b < nbt; b++) v[8*b +: 8] = mm[int'(a) + b];
        if (!u && v[8*nbt-1]) v = v | ~((64'd1 << (8*nbt)) - 64'd1);
        erd = {32'b0, v[31:0]};
      end
      xact(0, w, a, sz, u, wd, erd, 0, 1, 0, w ? "rnd_st" : "rnd_ld");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_extend();
    test_errors();
    test_latency();
    test_double();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
